vga_timing_gen: RTL and testbench

//  Raster timing source and pin driver for the XVGA display path (1024x768@60, 65 MHz pixel clock).

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/sync_delay_line.sv | 38 +++
 rtl/vga_timing_gen.sv | 172 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants and pixel type for the XVGA (1024x768@60) display path.
// Holds the colour-bar table when VGA_TEST_PATTERN_EN is defined.
package vga_timing_pkg;

  localparam int XVGA_H_ACTIVE    = 1024;
  localparam int XVGA_H_FP        = 24;
  localparam int XVGA_H_SYNC      = 136;
  localparam int XVGA_H_BP        = 160;
  localparam int XVGA_V_ACTIVE    = 768;
  localparam int XVGA_V_FP        = 3;
  localparam int XVGA_V_SYNC      = 6;
  localparam int XVGA_V_BP        = 29;
  localparam logic XVGA_SYNC_POL  = 1'b0;
  localparam int XVGA_PIPE_STAGES = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

`ifdef VGA_TEST_PATTERN_EN
  // White, yellow, cyan, green, magenta, red, blue, black
  localparam logic [11:0] BAR_COLOURS [0:7] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };
`endif

endpackage

// File: rtl/sync_delay_line.sv
// Enabled shift register with asynchronous reset to RESET_VAL; DEPTH=0 is a plain wire.
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_regs
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift one stage per enabled cycle, hold otherwise
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= RESET_VAL;
          end
        end else if (en_in) begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter, sync generator and aligned pin driver for the VGA output.
// Optional VGA_TEST_PATTERN_EN adds test_pattern_in and an 8-bar colour pattern.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = XVGA_H_ACTIVE,
  parameter int   H_FP        = XVGA_H_FP,
  parameter int   H_SYNC      = XVGA_H_SYNC,
  parameter int   H_BP        = XVGA_H_BP,
  parameter int   V_ACTIVE    = XVGA_V_ACTIVE,
  parameter int   V_FP        = XVGA_V_FP,
  parameter int   V_SYNC      = XVGA_V_SYNC,
  parameter int   V_BP        = XVGA_V_BP,
  parameter logic SYNC_POL    = XVGA_SYNC_POL,
  parameter int   PIPE_STAGES = XVGA_PIPE_STAGES
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        en_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_pattern_in,
`endif
  input  logic [11:0] pixel_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        blank_out,
  output logic        frame_done_out,
  output logic [5:0]  frame_count_out,
  output logic [3:0]  vga_r_out,
  output logic [3:0]  vga_g_out,
  output logic [3:0]  vga_b_out,
  output logic        vga_hs_out,
  output logic        vga_vs_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if ((H_TOTAL > 2048) || (V_TOTAL > 1024) || (PIPE_STAGES < 0) || (PIPE_STAGES > 8)) begin : g_bad_cfg
      $error("vga_timing_gen: unsupported timing or PIPE_STAGES configuration");
    end
  endgenerate

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_W      = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_W      = 10'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam int DLY_W = 6;
  localparam logic [DLY_W-1:0] DLY_RST = {3'b000, ~SYNC_POL, ~SYNC_POL, 1'b1};
`else
  localparam int DLY_W = 3;
  localparam logic [DLY_W-1:0] DLY_RST = {~SYNC_POL, ~SYNC_POL, 1'b1};
`endif

  logic [10:0]      hcount_r;
  logic [9:0]       vcount_r;
  logic [5:0]       frame_count_r;
  logic             hs_raw_s;
  logic             vs_raw_s;
  logic             blank_s;
  logic [DLY_W-1:0] dly_in_s;
  logic [DLY_W-1:0] dly_out_s;
  rgb444_t          src_s;
  rgb444_t          rgb_r;
  logic             hs_r;
  logic             vs_r;

  // Raster counters: column, line and completed-frame count
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_r      <= 11'd0;
      vcount_r      <= 10'd0;
      frame_count_r <= 6'd0;
    end else if (en_in) begin
      if (hcount_r == H_LAST) begin
        hcount_r <= 11'd0;
        if (vcount_r == V_LAST) begin
          vcount_r      <= 10'd0;
          frame_count_r <= frame_count_r + 6'd1;
        end else begin
          vcount_r <= vcount_r + 10'd1;
        end
      end else begin
        hcount_r <= hcount_r + 11'd1;
      end
    end
  end

  // Raw syncs already carry pin polarity so the delay line needs no post-processing
  always_comb begin
    hs_raw_s = ~SYNC_POL;
    vs_raw_s = ~SYNC_POL;
    if ((hcount_r >= H_SYNC_START) && (hcount_r < H_SYNC_END)) begin
      hs_raw_s = SYNC_POL;
    end else begin
      hs_raw_s = ~SYNC_POL;
    end
    if ((vcount_r >= V_SYNC_START) && (vcount_r < V_SYNC_END)) begin
      vs_raw_s = SYNC_POL;
    end else begin
      vs_raw_s = ~SYNC_POL;
    end
  end

  assign blank_s = (hcount_r >= H_ACT_W) || (vcount_r >= V_ACT_W);

`ifdef VGA_TEST_PATTERN_EN
  assign dly_in_s = {hcount_r[9:7], hs_raw_s, vs_raw_s, blank_s};
`else
  assign dly_in_s = {hs_raw_s, vs_raw_s, blank_s};
`endif

  sync_delay_line #(
    .WIDTH     (DLY_W),
    .DEPTH     (PIPE_STAGES),
    .RESET_VAL (DLY_RST)
  ) u_sync_delay_line (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en_in    (en_in),
    .din      (dly_in_s),
    .dout     (dly_out_s)
  );

  // Colour source for the output register
  always_comb begin
    src_s = rgb444_t'(pixel_in);
`ifdef VGA_TEST_PATTERN_EN
    if (test_pattern_in) begin
      src_s = rgb444_t'(BAR_COLOURS[dly_out_s[5:3]]);
    end else begin
      src_s = rgb444_t'(pixel_in);
    end
`endif
  end

  // Pin register: pixel masked by the aligned blank, plus the aligned syncs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rgb_r <= rgb444_t'(12'h000);
      hs_r  <= ~SYNC_POL;
      vs_r  <= ~SYNC_POL;
    end else if (en_in) begin
      hs_r <= dly_out_s[2];
      vs_r <= dly_out_s[1];
      if (dly_out_s[0]) begin
        rgb_r <= rgb444_t'(12'h000);
      end else begin
        rgb_r <= src_s;
      end
    end
  end

  assign hcount_out      = hcount_r;
  assign vcount_out      = vcount_r;
  assign frame_count_out = frame_count_r;
  assign blank_out       = blank_s;
  assign frame_done_out  = en_in && (hcount_r == H_LAST) && (vcount_r == V_LAST);
  assign vga_r_out       = rgb_r.r;
  assign vga_g_out       = rgb_r.g;
  assign vga_b_out       = rgb_r.b;
  assign vga_hs_out      = hs_r;
  assign vga_vs_out      = vs_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full horizontal timing, shortened frame, PIPE_STAGES=2.
// Test-pattern checks are included when VGA_TEST_PATTERN_EN is defined.
module tb_vga_timing_gen;

  localparam int PS  = 2;
  localparam int HA  = 1024, HFP = 24, HSW = 136, HBP = 160;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VA  = 8, VFP = 2, VSW = 3, VBP = 3;
  localparam int VT  = VA + VFP + VSW + VBP;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        en_in;
  logic        tp;
  logic [11:0] pixel_in;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        blank_out, frame_done_out;
  logic [5:0]  frame_count_out;
  logic [3:0]  vga_r_out, vga_g_out, vga_b_out;
  logic        vga_hs_out, vga_vs_out;

  int          checks = 0;
  int          errors = 0;
  longint      n;
  logic [11:0] exp_rgb;
  int          fd_count;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0), .PIPE_STAGES(PS)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .en_in           (en_in),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern_in (tp),
`endif
    .pixel_in        (pixel_in),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .blank_out       (blank_out),
    .frame_done_out  (frame_done_out),
    .frame_count_out (frame_count_out),
    .vga_r_out       (vga_r_out),
    .vga_g_out       (vga_g_out),
    .vga_b_out       (vga_b_out),
    .vga_hs_out      (vga_hs_out),
    .vga_vs_out      (vga_vs_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: everything derives from n, the count of enabled cycles since reset
  function automatic int mh(longint k);
    return int'(k % HT);
  endfunction

  function automatic int mv(longint k);
    return int'((k / HT) % VT);
  endfunction

  function automatic logic mblank(longint k);
    return (mh(k) >= HA) || (mv(k) >= VA);
  endfunction

  function automatic logic pin_hs(longint k);
    if (k < 0) return 1'b1;
    return !((mh(k) >= HA + HFP) && (mh(k) < HA + HFP + HSW));
  endfunction

  function automatic logic pin_vs(longint k);
    if (k < 0) return 1'b1;
    return !((mv(k) >= VA + VFP) && (mv(k) < VA + VFP + VSW));
  endfunction

  function automatic logic [11:0] pattern(longint k);
    int h, v;
    h = mh(k);
    v = mv(k);
    return {h[3:0], v[3:0], 4'hA};
  endfunction

  function automatic logic [11:0] bar(int h);
    case ((h / 128) % 8)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_outputs();
    logic [41:0] got, exp;
    got = {hcount_out, vcount_out, frame_count_out, blank_out,
           vga_r_out, vga_g_out, vga_b_out, vga_hs_out, vga_vs_out};
    exp = {11'(mh(n)), 10'(mv(n)), 6'((n / (HT * VT)) % 64), mblank(n),
           exp_rgb, pin_hs(n - PS - 1), pin_vs(n - PS - 1)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL scoreboard n=%0d got=%h want=%h", n, got, exp);
    end
  endtask

  // One clock: drive inputs, check frame_done, advance model, check registered outputs
  task automatic step(input logic en_v);
    longint k;
    logic   exp_fd;
    k = n - PS;
    en_in = en_v;
    if (k >= 0 && !mblank(k)) pixel_in = pattern(k);
    else pixel_in = ($urandom_range(0, 1) == 0) ? 12'hFFF : 12'($urandom);
    #1;
    exp_fd = en_v && (mh(n) == HT - 1) && (mv(n) == VT - 1);
    checks++;
    if (frame_done_out !== exp_fd) begin
      errors++;
      $display("FAIL frame_done n=%0d got=%b want=%b", n, frame_done_out, exp_fd);
    end
    if (frame_done_out) fd_count++;
    @(posedge clk_in);
    if (en_v) begin
      if (k < 0 || mblank(k)) exp_rgb = 12'h000;
      else if (tp) exp_rgb = bar(mh(k));
      else exp_rgb = pixel_in;
      n++;
    end
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic run_to(input longint target);
    while (n < target) step(1'b1);
  endtask

  // Assert reset at a falling edge, check the held state, release on a later falling edge
  task automatic do_reset();
    logic [25:0] got;
    rst_n_in = 1'b0;
    en_in = 1'b1;
    #1;
    got = {hcount_out, vcount_out, vga_r_out, vga_g_out, vga_b_out, vga_hs_out, vga_vs_out};
    checks++;
    if (got !== {11'd0, 10'd0, 12'h000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", got, {11'd0, 10'd0, 12'h000, 1'b1, 1'b1});
    end
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    n = 0;
    exp_rgb = 12'h000;
    fd_count = 0;
    check_outputs();
  endtask

  task automatic check_rgb(input string name, input logic [11:0] want);
    logic [11:0] got;
    got = {vga_r_out, vga_g_out, vga_b_out};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s n=%0d got=%h want=%h", name, n, got, want);
    end
  endtask

  typedef struct {
    longint      n;
    int          h;
    int          v;
    int          fc;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic [40:0] got_v, exp_v;
    rst_n_in = 1'b0;
    en_in    = 1'b0;
    tp       = 1'b0;
    pixel_in = 12'h000;
    n        = 0;
    exp_rgb  = 12'h000;
    fd_count = 0;

    // Hand-derived checkpoints after reset with en_in held high (pins lag 3 cycles)
    tbl[0]  = '{0,     0,    0,  0, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[1]  = '{3,     3,    0,  0, 1'b1, 1'b1, 1'b0, 12'h00A};
    tbl[2]  = '{4,     4,    0,  0, 1'b1, 1'b1, 1'b0, 12'h10A};
    tbl[3]  = '{1023,  1023, 0,  0, 1'b1, 1'b1, 1'b0, 12'hC0A};
    tbl[4]  = '{1024,  1024, 0,  0, 1'b1, 1'b1, 1'b1, 12'hD0A};
    tbl[5]  = '{1026,  1026, 0,  0, 1'b1, 1'b1, 1'b1, 12'hF0A};
    tbl[6]  = '{1027,  1027, 0,  0, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[7]  = '{1050,  1050, 0,  0, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[8]  = '{1051,  1051, 0,  0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[9]  = '{1186,  1186, 0,  0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[10] = '{1187,  1187, 0,  0, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[11] = '{1344,  0,    1,  0, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[12] = '{1347,  3,    1,  0, 1'b1, 1'b1, 1'b0, 12'h01A};
    tbl[13] = '{13442, 2,    10, 0, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[14] = '{13443, 3,    10, 0, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[15] = '{17474, 2,    13, 0, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[16] = '{17475, 3,    13, 0, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[17] = '{21503, 1343, 15, 0, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[18] = '{21507, 3,    0,  1, 1'b1, 1'b1, 1'b0, 12'h00A};

    @(negedge clk_in);
    do_reset();

    for (int i = 0; i < 19; i++) begin
      run_to(tbl[i].n);
      got_v = {hcount_out, vcount_out, frame_count_out, vga_hs_out, vga_vs_out, blank_out,
               vga_r_out, vga_g_out, vga_b_out};
      exp_v = {11'(tbl[i].h), 10'(tbl[i].v), 6'(tbl[i].fc), tbl[i].hs, tbl[i].vs,
               tbl[i].blank, tbl[i].rgb};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL table[%0d] n=%0d got=%h want=%h", i, tbl[i].n, got_v, exp_v);
      end
    end
    checks++;
    if (fd_count != 1) begin
      errors++;
      $display("FAIL frame_done_count got=%0d want=1", fd_count);
    end

    // Reset in the middle of a line: pins stay blank until PS+1 enabled cycles after release
    run_to(n + 500);
    do_reset();
    step(1'b1);
    step(1'b1);
    check_rgb("post_reset_blank", 12'h000);
    step(1'b1);
    check_rgb("post_reset_first_pixel", 12'h00A);

`ifdef VGA_TEST_PATTERN_EN
    do_reset();
    tp = 1'b1;
    run_to(3);
    check_rgb("bar_white", 12'hFFF);
    run_to(131);
    check_rgb("bar_yellow", 12'hFF0);
    run_to(643);
    check_rgb("bar_red", 12'hF00);
    run_to(899);
    check_rgb("bar_black", 12'h000);
    run_to(1027);
    check_rgb("bar_porch", 12'h000);
    tp = 1'b0;
    run_to(n + 300);
`endif

    // Random stalls: model advances only on enabled cycles
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
